// File: rtl/swivm_uart_tx_pkg.sv
// Shared definitions for the SwiVM UART transmitter: register offsets, STATUS bit
// positions, TX state encoding and the default window base.
package swivm_uart_tx_pkg;

  localparam logic [15:0] SWIVM_BASE_DEFAULT = 16'hFF00;

  localparam logic [1:0] UART_DATA    = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_DIVISOR = 2'd2;
  localparam logic [1:0] UART_CTRL    = 2'd3;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // A programmed divisor of zero behaves as one cycle per bit.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/swivm_uart_tx_fifo.sv
// Byte FIFO for the UART transmitter; a push on the same edge as a pop is
// accepted even when full.
module swivm_uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/swivm_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the SwiVM CPU bus.
// Optional interrupt output and CTRL register are built with `define SWIVM_UART_IRQ_EN.
module swivm_uart_tx
  import swivm_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE       = SWIVM_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [31:0] i_wrdata,
  input  logic [1:0]  i_size,
  input  logic        i_we,
  output logic [31:0] o_rddata,
  output logic        o_sel,
  output logic        o_tx
`ifdef SWIVM_UART_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [1:0]  off;
  logic        wr_en;
  logic        push;
  logic        pop;
  logic [7:0]  head;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        ovf;
  logic [15:0] divisor;
  logic [31:0] status;

  tx_state_t   state, state_n;
  logic [15:0] div_q, div_n;
  logic [15:0] bcnt, bcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [2:0]  bitn, bitn_n;
  logic        tx_n;

  // Width, byte lanes and upper write data are not used by this device.
  logic unused_bits;
  assign unused_bits = ^{i_size, i_addr[1:0], i_wrdata[31:16]};

  assign o_sel = (i_addr[15:4] == BASE[15:4]);
  assign off   = i_addr[3:2];
  assign wr_en = !i_we && o_sel;
  assign push  = wr_en && (off == UART_DATA);

  swivm_uart_tx_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .push    (push),
    .pop     (pop),
    .din     (i_wrdata[7:0]),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ovf     <= 1'b0;
      divisor <= DIV_RESET;
    end else begin
      if (push && full && !pop)
        ovf <= 1'b1;
      else if (wr_en && off == UART_STATUS && i_wrdata[ST_OVF])
        ovf <= 1'b0;
      if (wr_en && off == UART_DIVISOR)
        divisor <= i_wrdata[15:0];
    end
  end

`ifdef SWIVM_UART_IRQ_EN
  logic irq_en;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      irq_en <= 1'b0;
      o_irq  <= 1'b0;
    end else begin
      if (wr_en && off == UART_CTRL) irq_en <= i_wrdata[0];
      o_irq <= irq_en && empty && (state == TX_IDLE);
    end
  end
`endif

  always_comb begin
    status                        = '0;
    status[ST_FULL]               = full;
    status[ST_EMPTY]              = empty;
    status[ST_OVF]                = ovf;
    status[ST_BUSY]               = (state != TX_IDLE);
    status[ST_COUNT_LSB +: 8]     = 8'(count);
  end

  always_comb begin
    o_rddata = '0;
    if (o_sel) begin
      case (off)
        UART_STATUS:  o_rddata = status;
        UART_DIVISOR: o_rddata = {16'd0, divisor};
`ifdef SWIVM_UART_IRQ_EN
        UART_CTRL:    o_rddata = {31'd0, irq_en};
`endif
        default:      o_rddata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= TX_IDLE;
      div_q <= 16'd1;
      bcnt  <= '0;
      shreg <= '0;
      bitn  <= '0;
      o_tx  <= 1'b1;
    end else begin
      state <= state_n;
      div_q <= div_n;
      bcnt  <= bcnt_n;
      shreg <= shreg_n;
      bitn  <= bitn_n;
      o_tx  <= tx_n;
    end
  end

  // The divisor is sampled only when a frame starts, so mid-frame writes wait.
  always_comb begin
    state_n = state;
    div_n   = div_q;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    bitn_n  = bitn;
    tx_n    = o_tx;
    pop     = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = head;
          div_n   = eff_div(divisor);
          bcnt_n  = eff_div(divisor) - 16'd1;
          tx_n    = 1'b0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (bcnt == 16'd0) begin
          bcnt_n  = div_q - 16'd1;
          tx_n    = shreg[0];
          shreg_n = {1'b0, shreg[7:1]};
          bitn_n  = 3'd0;
          state_n = TX_DATA;
        end else begin
          bcnt_n = bcnt - 16'd1;
        end
      end
      TX_DATA: begin
        if (bcnt == 16'd0) begin
          bcnt_n = div_q - 16'd1;
          if (bitn == 3'd7) begin
            tx_n    = 1'b1;
            state_n = TX_STOP;
          end else begin
            tx_n    = shreg[0];
            shreg_n = {1'b0, shreg[7:1]};
            bitn_n  = bitn + 3'd1;
          end
        end else begin
          bcnt_n = bcnt - 16'd1;
        end
      end
      TX_STOP: begin
        if (bcnt == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = head;
            div_n   = eff_div(divisor);
            bcnt_n  = eff_div(divisor) - 16'd1;
            tx_n    = 1'b0;
            state_n = TX_START;
          end else begin
            state_n = TX_IDLE;
          end
        end else begin
          bcnt_n = bcnt - 16'd1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_swivm_uart_tx.sv
// Bench for swivm_uart_tx: bus-side directed vectors, with a line monitor that
// decodes each 8N1 frame and checks it against a queue of expected bytes.
module tb_swivm_uart_tx;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [31:0] wrdata = 32'h0;
  logic [1:0]  size = 2'b00;
  logic        we = 1'b1;
  logic [31:0] rddata;
  logic        sel;
  logic        tx;
`ifdef SWIVM_UART_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t exp_q[$];
  int     cur_div = 434;

  swivm_uart_tx dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_addr   (addr),
    .i_wrdata (wrdata),
    .i_size   (size),
    .i_we     (we),
    .o_rddata (rddata),
    .o_sel    (sel),
    .o_tx     (tx)
`ifdef SWIVM_UART_IRQ_EN
    ,
    .o_irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wrdata = d; we = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b1; addr = 16'h0000;
  endtask

  task automatic send(input logic [7:0] b);
    bus_write(BASE, {24'd0, b});
    exp_q.push_back('{data: b, div: cur_div});
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(BASE + 16'h8, {16'd0, d});
    cur_div = (d == 16'd0) ? 1 : int'(d);
  endtask

  task automatic bus_read(input logic [15:0] a, input string name, input logic [31:0] exp);
    @(negedge clk);
    addr = a; we = 1'b1;
    #1;
    check(name, rddata, exp);
  endtask

  task automatic peek_status(output logic [31:0] v);
    addr = BASE + 16'h4;
    #1;
    v = rddata;
    addr = 16'h0000;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Line monitor: each start bit consumes one expected frame; reset discards all.
  initial begin
    frame_t     e;
    logic [7:0] got;
    logic       ok;
    logic       aborted;
    logic       expb;
    int         b;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else if (tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit seen, no frame expected");
          for (int k = 0; k < 5000 && tx == 1'b0; k++) @(negedge clk);
        end else begin
          e = exp_q.pop_front();
          ok = 1'b1; aborted = 1'b0; got = 8'h00;
          for (int j = 0; j < 10 * e.div; j++) begin
            if (j > 0) @(negedge clk);
            if (rst) begin
              aborted = 1'b1;
              break;
            end
            b = j / e.div;
            expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : e.data[b-1];
            if (tx !== expb) ok = 1'b0;
            if (b >= 1 && b <= 8 && (j % e.div) == e.div / 2) got[b-1] = tx;
          end
          if (aborted) exp_q.delete();
          else begin
            check("frame_shape", {31'd0, ok}, 32'd1);
            check("frame_data", {24'd0, got}, {24'd0, e.data});
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] st;
    int          bad;

    repeat (3) @(negedge clk);
    check("reset_tx_high", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    bus_read(BASE + 16'h4, "reset_status", 32'h0000_0002);
    check("sel_in_window", {31'd0, sel}, 32'd1);
    bus_read(BASE + 16'h8, "reset_divisor", 32'd434);
    bus_read(BASE, "data_reads_zero", 32'h0);

    // 0x55 at four cycles per bit: 40-cycle frame starting one edge after the write.
    set_div(16'd4);
    send(8'h55);
    check("t1_tx_on_write_edge", {31'd0, tx}, 32'd1);
    wait_cycles(1);
    check("t1_start_bit", {31'd0, tx}, 32'd0);
    wait_cycles(39);
    peek_status(st);
    check("t1_busy_last_cycle", st, 32'h0000_000A);
    wait_cycles(1);
    peek_status(st);
    check("t1_idle_after_40", st, 32'h0000_0002);

    // Back-to-back bytes: busy never drops across the 80 cycles of two frames.
    send(8'h41);
    send(8'h42);
    bad = 0;
    addr = BASE + 16'h4;
    for (int i = 0; i < 80; i++) begin
      #1;
      if (rddata[3] !== 1'b1) bad++;
      @(posedge clk);
    end
    #1;
    check("t2_busy_throughout", bad, 0);
    check("t2_status_after_80", rddata, 32'h0000_0002);
    addr = 16'h0000;

    // Divisor 0 acts as 1: a 10-cycle frame.
    set_div(16'd0);
    bus_read(BASE + 16'h8, "t5_divisor_reads_0", 32'h0);
    send(8'hFF);
    wait_cycles(10);
    peek_status(st);
    check("t5_busy_cycle_10", st, 32'h0000_000A);
    wait_cycles(1);
    peek_status(st);
    check("t5_idle_cycle_11", st, 32'h0000_0002);
    bus_read(BASE + 16'h10, "t5_rddata_outside", 32'h0);
    check("t5_sel_outside", {31'd0, sel}, 32'd0);

`ifdef SWIVM_UART_IRQ_EN
    set_div(16'd2);
    bus_write(BASE + 16'hC, 32'h1);
    wait_cycles(2);
    check("t6_irq_idle", {31'd0, irq}, 32'd1);
    bus_read(BASE + 16'hC, "t6_ctrl_readback", 32'h1);
    send(8'h3C);
    wait_cycles(3);
    check("t6_irq_busy", {31'd0, irq}, 32'd0);
    wait_cycles(25);
    check("t6_irq_done", {31'd0, irq}, 32'd1);
`else
    bus_write(BASE + 16'hC, 32'h1);
    bus_read(BASE + 16'hC, "ctrl_absent_reads_0", 32'h0);
`endif

    // Overflow: the first byte moves straight into the shifter, 16 more fill
    // the FIFO, so the 18th write is the one dropped.
    set_div(16'd200);
    send(8'h00);
    for (int i = 1; i <= 16; i++) send(8'(i));
    bus_write(BASE, 32'h0000_00EE);
    bus_read(BASE + 16'h4, "t3_full_ovf", 32'h0000_100D);
    bus_write(BASE + 16'h4, 32'h4);
    bus_read(BASE + 16'h4, "t3_ovf_cleared", 32'h0000_1009);

    // Reset in the middle of the first (all-zero) data bits.
    wait_cycles(400);
    check("t4_tx_in_data", {31'd0, tx}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("t4_async_tx_high", {31'd0, tx}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_div = 434;
    bus_read(BASE + 16'h4, "t4_status_after_reset", 32'h0000_0002);
    bus_read(BASE + 16'h8, "t4_divisor_after_reset", 32'd434);

    wait_cycles(20);
    check("frames_outstanding", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
